// File: rtl/lb_pkg.sv
// -----------------------------------------------------------------------------
// lb_pkg
// Shared definitions for the M10K line-buffer read-side controller.
//   PIX_W          : pixel width in bits
//   DEF_H_ACTIVE   : default pixels per line
//   DEF_V_ACTIVE   : default lines per frame
//   lb_state_e     : read controller states (IDLE, RUN, GAP)
// -----------------------------------------------------------------------------
package lb_pkg;

  localparam int unsigned PIX_W        = 8;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } lb_state_e;

endpackage

// File: rtl/lb_pos_counter.sv
// -----------------------------------------------------------------------------
// lb_pos_counter
// Column/row position counters for the line-buffer reader. Advances on each
// pop strobe, wrapping the column at H_ACTIVE-1 (and bumping the row) and the
// row at V_ACTIVE-1. The tags describe the position of the pixel that the
// next pop will fetch.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   pop        : one pixel is being read from the buffer this cycle
//   col, row   : position of the next pixel to be popped
//   is_sol     : next pixel is column 0
//   is_eol     : next pixel is column H_ACTIVE-1
//   is_eof     : next pixel is the last pixel of the frame
// -----------------------------------------------------------------------------
module lb_pos_counter #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned COL_W    = 10,
  parameter int unsigned ROW_W    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pop,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             is_sol,
  output logic             is_eol,
  output logic             is_eof
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

  assign is_sol = (col == '0);
  assign is_eol = (col == COL_LAST);
  assign is_eof = is_eol && (row == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pop) begin
      if (is_eol) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/line_buff_reader.sv
// -----------------------------------------------------------------------------
// line_buff_reader
// Read-side controller for the M10K line buffer. Pops the buffer whenever it
// is non-empty and the one-deep output register is free (or being drained
// the same cycle), tags each pixel with position and line/frame markers, and
// inserts GAP_CYCLES idle cycles after every line so the downstream Sobel
// window pipeline can drain. After the last pixel of a frame it returns to
// IDLE and waits for enable again.
//
// Optional feature (macro LB_RD_UNDERRUN_CNT_EN): adds underrun_cnt, a
// saturating count of RUN cycles where the output could accept a pixel but
// the buffer was empty. Cleared on each IDLE->RUN start.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : start streaming a frame (sampled only in IDLE)
//   lb_data      : buffer read data at the current read index
//   lb_flag      : buffer non-empty
//   lb_read_en   : pop strobe to the buffer (combinational)
//   pix_data     : output pixel
//   pix_valid    : output register holds a pixel
//   pix_ready    : downstream accepts the pixel
//   pix_sol/eol/eof : start-of-line / end-of-line / end-of-frame tags
//   col_idx, row_idx : position of pix_data
//   underrun_cnt : (LB_RD_UNDERRUN_CNT_EN only) starvation cycle counter
// -----------------------------------------------------------------------------
module line_buff_reader
  import lb_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned ROW_W      = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [PIX_W-1:0] lb_data,
  input  logic             lb_flag,
  output logic             lb_read_en,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_sol,
  output logic             pix_eol,
  output logic             pix_eof,
  output logic [COL_W-1:0] col_idx,
  output logic [ROW_W-1:0] row_idx
`ifdef LB_RD_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_cnt
`endif
);

  localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  lb_state_e         state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              eof_pend_q, eof_pend_d;

  logic [COL_W-1:0]  pos_col;
  logic [ROW_W-1:0]  pos_row;
  logic              pos_sol, pos_eol, pos_eof;

  // Position of the pixel the next pop fetches.
  lb_pos_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_pos (
    .clk    (clk),
    .rst_n  (rst_n),
    .pop    (lb_read_en),
    .col    (pos_col),
    .row    (pos_row),
    .is_sol (pos_sol),
    .is_eol (pos_eol),
    .is_eof (pos_eof)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      eof_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      eof_pend_q <= eof_pend_d;
    end
  end

  // Next-state and pop strobe
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    eof_pend_d = eof_pend_q;
    lb_read_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        // Pop only when the output register is empty or is being drained
        // this cycle, which gives full throughput without a skid buffer.
        lb_read_en = lb_flag && (!pix_valid || pix_ready);
        if (lb_read_en && pos_eol) begin
          if (GAP_CYCLES == 0) begin
            state_d = pos_eof ? IDLE : RUN;
          end else begin
            state_d    = GAP;
            gap_d      = GW'(GAP_LOAD);
            eof_pend_d = pos_eof;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d    = eof_pend_q ? IDLE : RUN;
          eof_pend_d = 1'b0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-deep output register. Tags and indices are only rewritten on a pop,
  // so they stay stable while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_sol   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
      col_idx   <= '0;
      row_idx   <= '0;
    end else if (lb_read_en) begin
      pix_data  <= lb_data;
      pix_valid <= 1'b1;
      pix_sol   <= pos_sol;
      pix_eol   <= pos_eol;
      pix_eof   <= pos_eof;
      col_idx   <= pos_col;
      row_idx   <= pos_row;
    end else if (pix_ready) begin
      pix_valid <= 1'b0;
    end
  end

`ifdef LB_RD_UNDERRUN_CNT_EN
  // Starvation: RUN, output able to take a pixel, buffer empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (state_q == IDLE && state_d == RUN) begin
      underrun_cnt <= '0;
    end else if (state_q == RUN && !lb_flag && (!pix_valid || pix_ready) &&
                 underrun_cnt != '1) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_buff_reader.sv
module tb_line_buff_reader;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 2;
  localparam int unsigned FR = H * V;

  typedef struct {
    logic [7:0]  din;
    int unsigned col;
    int unsigned row;
    logic        sol;
    logic        eol;
    logic        eof;
  } vec_t;

  typedef struct {
    logic [7:0]  data;
    int unsigned col;
    int unsigned row;
    logic        sol;
    logic        eol;
    logic        eof;
  } cap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (GAP=2) and its buffer model ----------------
  logic        rst_n, enable, pix_ready, force_empty, flush;
  logic [7:0]  mem [0:255];
  int unsigned wp, rp;
  logic        lb_flag, lb_read_en;
  logic [7:0]  lb_data, pix_data;
  logic        pix_valid, pix_sol, pix_eol, pix_eof;
  logic [2:0]  col_idx;
  logic [1:0]  row_idx;
`ifdef LB_RD_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt, underrun1;
`endif

  assign lb_flag = (rp != wp) && !force_empty;
  assign lb_data = mem[rp[7:0]];

  always_ff @(posedge clk) begin
    if (flush)           rp <= wp;
    else if (lb_read_en) rp <= rp + 1;
  end

  line_buff_reader #(
    .H_ACTIVE (H), .V_ACTIVE (V), .GAP_CYCLES (2), .COL_W (3), .ROW_W (2)
  ) dut (
    .clk (clk), .rst_n (rst_n), .enable (enable),
    .lb_data (lb_data), .lb_flag (lb_flag), .lb_read_en (lb_read_en),
    .pix_data (pix_data), .pix_valid (pix_valid), .pix_ready (pix_ready),
    .pix_sol (pix_sol), .pix_eol (pix_eol), .pix_eof (pix_eof),
    .col_idx (col_idx), .row_idx (row_idx)
`ifdef LB_RD_UNDERRUN_CNT_EN
    , .underrun_cnt (underrun_cnt)
`endif
  );

  // ---------------- zero-gap DUT, fixed 8-entry buffer holding 0..7 -------
  logic        en1, flag1, pop1;
  int unsigned rp1;
  logic [7:0]  d1, q1_data;
  logic        q1_valid, q1_sol, q1_eol, q1_eof;
  logic [2:0]  q1_col;
  logic [1:0]  q1_row;

  assign flag1 = (rp1 < 8);
  assign d1    = 8'(rp1);

  always_ff @(posedge clk) begin
    if (flush)     rp1 <= 0;
    else if (pop1) rp1 <= rp1 + 1;
  end

  line_buff_reader #(
    .H_ACTIVE (H), .V_ACTIVE (V), .GAP_CYCLES (0), .COL_W (3), .ROW_W (2)
  ) dut_zg (
    .clk (clk), .rst_n (rst_n), .enable (en1),
    .lb_data (d1), .lb_flag (flag1), .lb_read_en (pop1),
    .pix_data (q1_data), .pix_valid (q1_valid), .pix_ready (1'b1),
    .pix_sol (q1_sol), .pix_eol (q1_eol), .pix_eof (q1_eof),
    .col_idx (q1_col), .row_idx (q1_row)
`ifdef LB_RD_UNDERRUN_CNT_EN
    , .underrun_cnt (underrun1)
`endif
  );

  // ---------------- scoreboard state ----------------
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc, k, k1;
  logic [7:0]  exp_q[$];
  int unsigned pop_log[$];
  int unsigned pop1_log[$];
  cap_t        caps[$];
  logic        pv_prev, pr_prev;
  logic [31:0] hold_word;
  vec_t        tbl [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pw(input logic [7:0] d, input int unsigned c,
                                     input int unsigned r, input logic s,
                                     input logic e, input logic f);
    return {d, 8'(c), 8'(r), 5'b0, s, e, f};
  endfunction

  // Expected word for the kk-th pixel delivered since reset.
  function automatic logic [31:0] model_word(input logic [7:0] d, input int unsigned kk);
    int unsigned p;
    p = kk % FR;
    return pw(d, p % H, p / H, (p % H) == 0, (p % H) == H - 1, p == FR - 1);
  endfunction

  function automatic logic [31:0] cur_word();
    return pw(pix_data, 32'(col_idx), 32'(row_idx), pix_sol, pix_eol, pix_eof);
  endfunction

  task automatic load(input logic [7:0] b);
    mem[wp[7:0]] = b;
    exp_q.push_back(b);
    wp++;
  endtask

  // Observation at the falling edge; inputs are stable, the next rising
  // edge commits whatever handshake is seen here.
  task automatic monitor();
    cyc++;
    if (lb_read_en) pop_log.push_back(cyc);
    if (pop1)       pop1_log.push_back(cyc);
    if (pix_valid && !pix_ready) chk("stall_no_pop", 32'(lb_read_en), 0);
    if (pv_prev && !pr_prev) begin
      chk("hold_valid", 32'(pix_valid), 1);
      chk("hold_word", cur_word(), hold_word);
    end
    if (pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_pixel: got 0x%0h, expected no pixel", pix_data);
      end else begin
        logic [7:0] d;
        d = exp_q.pop_front();
        chk("pixel", cur_word(), model_word(d, k));
        k++;
        caps.push_back('{pix_data, 32'(col_idx), 32'(row_idx), pix_sol, pix_eol, pix_eof});
      end
    end
    if (q1_valid) begin
      chk("zg_pixel", pw(q1_data, 32'(q1_col), 32'(q1_row), q1_sol, q1_eol, q1_eof),
          model_word(8'(k1), k1));
      k1++;
    end
    pv_prev   = pix_valid;
    pr_prev   = pix_ready;
    hold_word = cur_word();
  endtask

  task automatic run_cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(pix_valid), 0);
    chk({tag, "_rden"},  32'(lb_read_en), 0);
    chk({tag, "_word"},  cur_word(), 0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; pix_ready = 1'b1; force_empty = 1'b0;
    flush = 1'b1; en1 = 1'b0; wp = 0; cyc = 0; k = 0; k1 = 0;
    pv_prev = 1'b0; pr_prev = 1'b1; hold_word = '0;

    for (int i = 0; i < 8; i++)
      tbl[i] = '{8'(8'h10 + i), i % 4, i / 4, (i % 4) == 0, (i % 4) == 3, i == 7};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    chk("reset_zg_valid", 32'(q1_valid), 0);
    flush = 1'b0;
    rst_n = 1'b1;

    // ---- basic stream (table) + zero-gap DUT in parallel ----
    for (int i = 0; i < 8; i++) load(tbl[i].din);
    pop_log.delete(); caps.delete();
    enable = 1'b1; en1 = 1'b1;
    run_cycle();
    enable = 1'b0; en1 = 1'b0;
    for (int c = 0; c < 40 && caps.size() < 8; c++) run_cycle();
    chk("basic_count", caps.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("basic_vec",
          pw(caps[i].data, caps[i].col, caps[i].row, caps[i].sol, caps[i].eol, caps[i].eof),
          pw(tbl[i].din, tbl[i].col, tbl[i].row, tbl[i].sol, tbl[i].eol, tbl[i].eof));
    chk("basic_pops", pop_log.size(), 8);
    chk("basic_line_b2b", pop_log[3] - pop_log[0], 3);
    chk("basic_gap", pop_log[4] - pop_log[3], 3);
    chk("zg_pops", pop1_log.size(), 8);
    chk("zg_span", pop1_log[7] - pop1_log[0], 7);

    // back in IDLE: data available but no pops without enable
    for (int i = 0; i < 8; i++) load(8'(8'h10 + i));
    repeat (3) run_cycle();
    pop_log.delete();
    repeat (8) run_cycle();
    chk("idle_no_pop", pop_log.size(), 0);

    // ---- backpressure right after the first capture ----
    caps.delete();
    enable = 1'b1;
    run_cycle();
    enable = 1'b0;
    for (int c = 0; c < 10 && pop_log.size() == 0; c++) run_cycle();
    pix_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(pix_valid), 1);
      chk("bp_data", 32'(pix_data), 32'h10);
      chk("bp_rden", 32'(lb_read_en), 0);
      monitor();
      @(posedge clk);
      #1;
    end
    pix_ready = 1'b1;
    for (int c = 0; c < 40 && caps.size() < 8; c++) run_cycle();
    chk("bp_count", caps.size(), 8);
    for (int i = 0; i < 8; i++) chk("bp_order", 32'(caps[i].data), 32'(8'h10 + i));
    repeat (6) run_cycle();

    // ---- empty buffer for 3 cycles after 0x11 pops ----
    for (int i = 0; i < 8; i++) load(8'(8'h10 + i));
    caps.delete(); pop_log.delete();
    enable = 1'b1;
    run_cycle();
    enable = 1'b0;
    for (int c = 0; c < 10 && pop_log.size() < 2; c++) run_cycle();
    force_empty = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("empty_no_pop", 32'(lb_read_en), 0);
      monitor();
      @(posedge clk);
      #1;
    end
    force_empty = 1'b0;
    @(negedge clk);
`ifdef LB_RD_UNDERRUN_CNT_EN
    chk("underrun_cnt", 32'(underrun_cnt), 3);
`endif
    monitor();
    @(posedge clk);
    #1;
    for (int c = 0; c < 40 && caps.size() < 8; c++) run_cycle();
    chk("empty_next_data", 32'(caps[2].data), 32'h12);
    chk("empty_next_col", caps[2].col, 2);
    repeat (6) run_cycle();

    // ---- enable dropped at pixel 2: frame completes, then IDLE ----
    for (int i = 0; i < 16; i++) load(8'(8'h40 + i));
    caps.delete(); pop_log.delete();
    enable = 1'b1;
    run_cycle();
    for (int c = 0; c < 10 && pop_log.size() < 2; c++) run_cycle();
    enable = 1'b0;
    for (int c = 0; c < 40 && caps.size() < 8; c++) run_cycle();
    chk("drop_eof", 32'(caps[7].eof), 1);
    chk("drop_last", 32'(caps[7].data), 32'h47);
    repeat (10) run_cycle();
    chk("drop_pops", pop_log.size(), 8);

    // ---- reset mid-frame after 5 pixels ----
    caps.delete();
    enable = 1'b1;
    run_cycle();
    enable = 1'b0;
    for (int c = 0; c < 20 && caps.size() < 5; c++) run_cycle();
    chk("rst_pre_count", caps.size(), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    flush = 1'b1;
    exp_q.delete(); caps.delete();
    k = 0; pv_prev = 1'b0; pr_prev = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) load(8'(8'h30 + i));
    enable = 1'b1;
    run_cycle();
    enable = 1'b0;
    for (int c = 0; c < 40 && caps.size() < 8; c++) run_cycle();
    chk("rst_first", pw(caps[0].data, caps[0].col, caps[0].row, caps[0].sol, caps[0].eol,
                        caps[0].eof), pw(8'h30, 0, 0, 1'b1, 1'b0, 1'b0));
    chk("rst_count", caps.size(), 8);
    repeat (6) run_cycle();

    // ---- randomized stream against the model ----
    for (int i = 0; i < 32; i++) load(8'($urandom_range(0, 255)));
    enable = 1'b1;
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) begin
      pix_ready   = ($urandom_range(0, 3) != 0);
      force_empty = ($urandom_range(0, 5) == 0);
      run_cycle();
    end
    enable = 1'b0; pix_ready = 1'b1; force_empty = 1'b0;
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_frame_align", k % FR, 0);
    repeat (4) run_cycle();
`ifdef LB_RD_UNDERRUN_CNT_EN
    chk("zg_underrun", 32'(underrun1), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
